// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for the single-issue RV32 datapath.
//   Fetches over a req/ack imem handshake into an instruction register, then
//   walks DECODE -> EXEC (exec_en pulse) -> WB (rf_we pulse, pc += 4).
//   Unsupported opcodes and fetch timeouts park the FSM in a sticky TRAP state.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   run                 level enable; leaves IDLE and keeps fetching while high
//   imem_req/addr       fetch request (FETCH only) and address (= pc)
//   imem_ack/rdata      fetch completion and instruction word
//   instr, pc           instruction register and current instruction address
//   exec_en, rf_we      one-cycle execute / register-writeback enables
//   busy, trap          activity flag, sticky trap flag
//   trap_cause          0 none, 1 illegal opcode, 2 fetch timeout
//   instret             retired-instruction count (only with SEQ_RETIRE_CNT_EN)
// Optional feature macro: SEQ_RETIRE_CNT_EN adds the instret counter output.

module multicycle_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        exec_en,
  output logic        rf_we,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam logic [31:0] NOP          = 32'h0000_0013;
  // Counter value seen in the last FETCH cycle that may still accept an ack.
  localparam logic [7:0]  TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  localparam logic [1:0]  CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0]  CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       opcode_ok;
  logic       fetch_expired;

  // Only OP-IMM, OP and LUI are executed by this datapath.
  always_comb begin
    opcode_ok = 1'b0;
    case (instr[6:0])
      7'h13, 7'h33, 7'h37: opcode_ok = 1'b1;
      default:             opcode_ok = 1'b0;
    endcase
  end

  assign fetch_expired = !imem_ack && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs. imem_ack only steers the next
  // state, so no output has a combinational path from it.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    exec_en   = 1'b0;
    rf_we     = 1'b0;
    busy      = 1'b1;
    trap      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)           state_nxt = S_DECODE;
        else if (fetch_expired) state_nxt = S_TRAP;
      end
      S_DECODE: begin
        state_nxt = opcode_ok ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        exec_en   = 1'b1;
        state_nxt = S_WB;
      end
      S_WB: begin
        // rd = x0 is architecturally discarded, so suppress the write.
        rf_we     = (instr[11:7] != 5'd0);
        state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        busy = 1'b0;
        trap = 1'b1;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      instr      <= NOP;
      wait_cnt   <= 8'd0;
      trap_cause <= 2'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            wait_cnt <= 8'd0;
          end else if (fetch_expired) begin
            wait_cnt   <= 8'd0;
            trap_cause <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          // pc is left untouched so it still points at the faulting word.
          if (!opcode_ok) trap_cause <= CAUSE_ILLEGAL;
        end
        S_WB: begin
          pc <= pc + 32'd4;
        end
        default: begin
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= 32'd0;
    end else if (state == S_WB) begin
      instret <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        exec_en;
  logic        rf_we;
  logic        busy;
  logic        trap;
  logic [1:0]  trap_cause;
`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] instret;
`endif

  multicycle_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .pc(pc), .exec_en(exec_en), .rf_we(rf_we),
    .busy(busy), .trap(trap), .trap_cause(trap_cause)
`ifdef SEQ_RETIRE_CNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Transaction-level model: an instruction is "in flight" while active;
  // m_age counts cycles since its fetch was acknowledged (0 = still fetching).
  bit          m_active;
  bit          m_trapped;
  int          m_age;
  int          m_wait;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [1:0]  m_cause;
  logic [31:0] m_instret;

  function automatic bit legal_op(input logic [31:0] w);
    return (w[6:0] == 7'h13) || (w[6:0] == 7'h33) || (w[6:0] == 7'h37);
  endfunction

  task automatic model_reset();
    m_active  = 0;
    m_trapped = 0;
    m_age     = 0;
    m_wait    = 0;
    m_pc      = RST_PC;
    m_instr   = 32'h0000_0013;
    m_cause   = 2'd0;
    m_instret = 32'd0;
  endtask

  task automatic model_step(input logic r, input logic a, input logic [31:0] d);
    if (m_trapped) return;
    if (!m_active) begin
      if (r) begin
        m_active = 1; m_age = 0; m_wait = 0;
      end
      return;
    end
    case (m_age)
      0: begin
        if (a) begin
          m_instr = d; m_age = 1; m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_trapped = 1; m_active = 0; m_cause = 2'd2;
          end
        end
      end
      1: begin
        if (legal_op(m_instr)) m_age = 2;
        else begin
          m_trapped = 1; m_active = 0; m_cause = 2'd1;
        end
      end
      2: m_age = 3;
      default: begin
        m_pc      = m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
        if (r) begin
          m_age = 0; m_wait = 0;
        end else begin
          m_active = 0;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic compare_all();
    logic exp_req;
    exp_req = m_active && (m_age == 0);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr", instr, m_instr);
    chk("pc", pc, m_pc);
    chk("exec_en", 32'(exec_en), 32'(m_active && m_age == 2));
    chk("rf_we", 32'(rf_we), 32'(m_active && m_age == 3 && m_instr[11:7] != 5'd0));
    chk("busy", 32'(busy), 32'(m_active));
    chk("trap", 32'(trap), 32'(m_trapped));
    chk("trap_cause", 32'(trap_cause), 32'(m_cause));
`ifdef SEQ_RETIRE_CNT_EN
    chk("instret", instret, m_instret);
`endif
  endtask

  // Called at a falling edge: apply inputs, clock once, check at next falling edge.
  task automatic step(input logic r, input logic a, input logic [31:0] d);
    run = r; imem_ack = a; imem_rdata = d;
    @(posedge clk);
    model_step(r, a, d);
    @(negedge clk);
    compare_all();
  endtask

  // Asserted between edges; outputs must respond before the next clock edge.
  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_async_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // From a visible FETCH cycle: ack immediately, finish through WB, back to FETCH.
  task automatic run_one(input logic [31:0] w);
    step(1'b1, 1'b1, w);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'h13, 7'h33, 7'h37, 7'h13, 7'h33, 7'h37, 7'h13, 7'h6F, 7'h03, 7'h63};
    logic [31:0] w;
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    int stall_left = 0;
    int trap_hold  = 0;
    logic r, a;

    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    model_reset();
    compare_all();
    chk("reset_pc", pc, 32'h0000_0000);
    chk("reset_instr", instr, 32'h0000_0013);
    rst = 1'b0;

    // addi x1,x0,5 with ack in the first FETCH cycle
    step(1, 0, 32'h0);                 chk("t1_req_c1", 32'(imem_req), 32'd1);
    step(1, 1, 32'h0050_0093);         chk("t1_instr", instr, 32'h0050_0093);
    step(1, 0, 32'h0);                 chk("t1_exec_c3", 32'(exec_en), 32'd1);
    step(1, 0, 32'h0);                 chk("t1_rfwe_c4", 32'(rf_we), 32'd1);
    step(1, 0, 32'h0);                 chk("t1_req_c5", 32'(imem_req), 32'd1);
                                       chk("t1_pc_c5", pc, 32'd4);
    // addi x0,x0,0: executes but no register write
    step(1, 1, 32'h0000_0013);
    step(1, 0, 32'h0);                 chk("t2_exec", 32'(exec_en), 32'd1);
    step(1, 0, 32'h0);                 chk("t2_rfwe_x0", 32'(rf_we), 32'd0);
    step(1, 0, 32'h0);                 chk("t2_pc", pc, 32'd8);
    // JAL at pc=8 traps as illegal
    step(1, 1, 32'h0000_006F);
    step(1, 0, 32'h0);                 chk("t3_trap", 32'(trap), 32'd1);
                                       chk("t3_cause", 32'(trap_cause), 32'd1);
                                       chk("t3_pc", pc, 32'd8);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h0050_0093);
    chk("t3_exec_off", 32'(exec_en), 32'd0);
    do_reset();                        chk("t3_pc_rst", pc, RST_PC);

    // Fetch timeout: 16 FETCH cycles without ack, TRAP in the 17th
    step(1, 0, 32'h0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(1, 0, 32'h0);
    chk("t4_req_c16", 32'(imem_req), 32'd1);
    step(1, 0, 32'h0);                 chk("t4_trap_c17", 32'(trap), 32'd1);
                                       chk("t4_cause", 32'(trap_cause), 32'd2);
                                       chk("t4_req_off", 32'(imem_req), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h0000_0013);
    chk("t4_trap_hold", 32'(trap), 32'd1);
    do_reset();

    // run dropped during EXEC: retire, go idle, then resume at pc+4
    step(1, 0, 32'h0);
    step(1, 1, 32'h0030_0193);
    step(1, 0, 32'h0);                 chk("t5_exec", 32'(exec_en), 32'd1);
    step(0, 0, 32'h0);                 chk("t5_rfwe", 32'(rf_we), 32'd1);
    step(0, 0, 32'h0);                 chk("t5_idle_busy", 32'(busy), 32'd0);
    step(0, 0, 32'h0);
    step(1, 0, 32'h0);                 chk("t5_refetch", imem_addr, 32'd4);
                                       chk("t5_refetch_req", 32'(imem_req), 32'd1);
    do_reset();

    // Retire counting, then async reset in the middle of a fetch
    step(1, 0, 32'h0);
    run_one(32'h0050_0093);
    run_one(32'h0000_0013);
    run_one(32'h1234_50B7);
    step(1, 1, 32'h0000_006F);
    step(1, 0, 32'h0);                 chk("t6_trap", 32'(trap), 32'd1);
`ifdef SEQ_RETIRE_CNT_EN
    chk("t6_instret3", instret, 32'd3);
`endif
    do_reset();
    step(1, 0, 32'h0);
    run_one(32'h0050_0093);
    step(1, 0, 32'h0);
    do_reset();                        // mid-FETCH
`ifdef SEQ_RETIRE_CNT_EN
    chk("t6_instret_clr", instret, 32'd0);
`endif

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      if (m_trapped && trap_hold >= 3) begin
        do_reset();
        trap_hold = 0;
      end else if (m_active && m_age == 0 && $urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        r = ($urandom_range(0, 7) != 0);
        if (stall_left > 0) begin
          a = 1'b0;
          stall_left--;
        end else begin
          if ($urandom_range(0, 149) == 0) stall_left = $urandom_range(10, 20);
          a = ($urandom_range(0, 2) != 0);
        end
        step(r, a, rand_instr());
        if (m_trapped) trap_hold++;
        else trap_hold = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the single-issue RV32 datapath.
- Fetches instructions over a request/ack instruction-memory handshake and holds them in an instruction register that drives the decoder's instr input.
- Pulses execute and register-writeback enables, then advances the PC.
- Traps on unsupported opcodes or a fetch timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, FETCH-state cycles without imem_ack before trapping; range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 lets the sequencer leave IDLE and continue fetching.
- imem_req  output  1  fetch request; held high for the whole FETCH state.
- imem_addr  output  32  fetch address, equal to pc while imem_req is high.
- imem_ack  input  1  fetch complete; sampled only while imem_req=1.
- imem_rdata  input  32  instruction word; valid in the cycle imem_ack=1.
- instr  output  32  instruction register, fed to the decoder.
- pc  output  32  address of the current instruction.
- exec_en  output  1  one-cycle pulse in EXEC; ALU result latched.
- rf_we  output  1  one-cycle register-file write enable in WB.
- busy  output  1  1 in every state except IDLE and TRAP.
- trap  output  1  sticky trap flag.
- trap_cause  output  2  0 = none, 1 = illegal opcode, 2 = fetch timeout.

Behaviour:
- Reset (asynchronous, immediate, including mid-fetch):
  - State IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP).
  - imem_req, exec_en, rf_we, busy, trap = 0; trap_cause=0; timeout counter=0.
- States: IDLE, FETCH, DECODE, EXEC, WB, TRAP. All outputs are registered or decoded from state only; no combinational path from imem_ack to any output.
- IDLE:
  - run=1 -> FETCH next cycle.
  - Otherwise stay in IDLE.
- FETCH:
  - imem_req=1, imem_addr=pc. The counter increments each cycle imem_ack=0.
  - imem_ack=1 -> instr<=imem_rdata, counter cleared, -> DECODE. This holds even if imem_ack rises in the first FETCH cycle.
  - Counter reaches FETCH_TIMEOUT with no ack -> TRAP, trap_cause=2. imem_req drops on TRAP entry.
  - imem_ack outside FETCH is ignored.
- DECODE (1 cycle), on opcode instr[6:0]:
  - 7'h13 (OP-IMM), 7'h33 (OP), 7'h37 (LUI) -> EXEC.
  - Any other opcode -> TRAP, trap_cause=1. pc is held at the faulting instruction.
- EXEC (1 cycle): exec_en=1 -> WB.
- WB (1 cycle):
  - rf_we=1 only if instr[11:7] != 0. Writes to x0 are suppressed with rf_we=0.
  - pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - run=1 -> FETCH; run=0 -> IDLE.
- TRAP:
  - trap=1, busy=0, all enables 0.
  - Absorbing state; only rst exits it. run is ignored.
- Throughput: 4 cycles per instruction when imem_ack arrives in the first FETCH cycle; each fetch wait cycle adds 1.
- run deasserted mid-instruction: the current instruction completes through WB, then the FSM goes to IDLE. No partial retire.
- exec_en and rf_we never assert in the same cycle. imem_req never asserts outside FETCH.

Optional Feature:
- Macro: SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output instret [31:0], reset to 0.
  - Increments by 1 in each WB cycle, including rd=x0 writes; wraps at 2^32.
  - Not incremented on trap.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, run=1, ack in the same cycle as req, imem_rdata=32'h00500093 (addi x1,x0,5): imem_req in cycle 1, exec_en in cycle 3, rf_we in cycle 4; pc becomes 4; imem_req again in cycle 5.
- Instruction 32'h00000013 (addi x0,x0,0): exec_en pulses, rf_we stays 0, pc advances by 4.
- Ack withheld for FETCH_TIMEOUT=16 cycles: trap=1 and trap_cause=2 on the 17th cycle; imem_req=0; state holds with run=1 until rst.
- Fetch 32'h0000006F (JAL, unsupported) at pc=8: trap_cause=1, pc stays 8, no exec_en or rf_we; rst restores pc=RESET_PC.
- run drops during EXEC: WB completes with rf_we=1, then IDLE with busy=0; run reasserted -> FETCH at pc+4.
- With SEQ_RETIRE_CNT_EN: 3 retired instructions followed by a trap gives instret=3; rst asserted mid-FETCH clears instret and drops imem_req asynchronously, before the next clock edge.
